// File: rtl/tt_spi_pkg.sv
// Shared types and constants for the SPI register responder.
package tt_spi_pkg;

  localparam int   BYTE_W  = 8;
  localparam logic RW_READ = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } spi_state_e;

  // Full 7-bit address is compared, so aliases above NREGS never hit a register.
  function automatic logic addr_in_range(input logic [6:0] addr, input int nregs);
    return (int'({25'd0, addr}) < nregs);
  endfunction

endpackage

// File: rtl/tt_spi_regfile.sv
// NREGS x 8-bit register file: one synchronous write port, combinational read port,
// both range-checked against NREGS.
module tt_spi_regfile
  import tt_spi_pkg::*;
#(
  parameter int NREGS  = 8,
  parameter int ADDR_W = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [6:0]              waddr,
  input  logic [BYTE_W-1:0]       wdata,
  input  logic [6:0]              raddr,
  output logic [BYTE_W-1:0]       rdata,
  output logic [BYTE_W*NREGS-1:0] regs_flat
);

  logic [BYTE_W-1:0] regs_q [NREGS];
  logic [BYTE_W-1:0] regs_d [NREGS];

  // Next-state of each register: only the addressed, in-range entry takes wdata.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      if (we && addr_in_range(waddr, NREGS) && (waddr == 7'(i))) begin
        regs_d[i] = wdata;
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  // Register storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= {BYTE_W{1'b0}};
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read port; out-of-range addresses read as zero.
  always_comb begin
    if (addr_in_range(raddr, NREGS)) begin
      rdata = regs_q[raddr[ADDR_W-1:0]];
    end else begin
      rdata = {BYTE_W{1'b0}};
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign regs_flat[BYTE_W*g +: BYTE_W] = regs_q[g];
  end

endmodule

// File: rtl/tt_spi_responder.sv
// SPI mode-0 target with byte-wide register access: frame = {rw, addr[6:0]}, data.
// Optional burst mode with address auto-increment: define SPI_AUTOINC_EN.
module tt_spi_responder
  import tt_spi_pkg::*;
#(
  parameter int NREGS       = 8,
  parameter int ADDR_W      = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    sclk,
  input  logic                    cs_n,
  input  logic                    mosi,
  output logic                    miso,
  output logic                    miso_oe,
  output logic                    busy,
  output logic [BYTE_W*NREGS-1:0] regs_flat
);

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   cs_prev_q, cs_prev_d;

  spi_state_e        state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [6:0]        shift_q, shift_d;
  logic [6:0]        addr_q, addr_d;
  logic              rw_q, rw_d;
  logic [BYTE_W-1:0] tx_q, tx_d;
  logic              miso_q, miso_d;
  logic              load_q, load_d;
  logic              wr_pend_q, wr_pend_d;
  logic [6:0]        wr_addr_q, wr_addr_d;
  logic [BYTE_W-1:0] wr_data_q, wr_data_d;

  logic              sclk_s, cs_s, mosi_s;
  logic              sclk_rise_s, sclk_fall_s, cs_rise_s, cs_fall_s;
  logic [BYTE_W-1:0] rdata_s;

`ifdef SPI_AUTOINC_EN
  localparam logic [6:0] LOW_MASK = 7'((1 << ADDR_W) - 1);
`endif

  assign sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
  assign cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
  assign mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s        = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_prev_d = sclk_s;
  assign cs_prev_d   = cs_s;
  assign sclk_rise_s = sclk_s & ~sclk_prev_q;
  assign sclk_fall_s = ~sclk_s & sclk_prev_q;
  assign cs_rise_s   = cs_s & ~cs_prev_q;
  assign cs_fall_s   = ~cs_s & cs_prev_q;

  assign miso    = miso_q;
  assign miso_oe = ena & ~cs_s;
  assign busy    = (state_q != ST_IDLE);

  // Frame sequencing; deselect and ena=0 take priority over any sclk edge.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    tx_d      = tx_q;
    miso_d    = miso_q;
    load_d    = 1'b0;
    wr_pend_d = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (!ena || cs_rise_s) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 3'd0;
      miso_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          miso_d = 1'b0;
          if (cs_fall_s) begin
            state_d   = ST_CMD;
            bit_cnt_d = 3'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_CMD: begin
          miso_d = 1'b0;
          if (sclk_rise_s) begin
            shift_d   = {shift_q[5:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rw_d    = shift_q[6];
              addr_d  = {shift_q[5:0], mosi_s};
              state_d = ST_DATA;
              load_d  = 1'b1;
            end else begin
              state_d = ST_CMD;
            end
          end else begin
            state_d = ST_CMD;
          end
        end
        ST_DATA: begin
          // A load never coincides with a fall: sclk is at most f_clk/4.
          if (load_q) begin
            tx_d = rdata_s;
          end else if (sclk_fall_s) begin
            miso_d = (rw_q == RW_READ) ? tx_q[BYTE_W-1] : 1'b0;
            tx_d   = {tx_q[BYTE_W-2:0], 1'b0};
          end else begin
            tx_d = tx_q;
          end
          if (sclk_rise_s) begin
            shift_d   = {shift_q[5:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              wr_pend_d = (rw_q != RW_READ);
              wr_addr_d = addr_q;
              wr_data_d = {shift_q[6:0], mosi_s};
`ifdef SPI_AUTOINC_EN
              addr_d    = (addr_q & ~LOW_MASK) | ((addr_q + 7'd1) & LOW_MASK);
              load_d    = 1'b1;
              state_d   = ST_DATA;
`else
              state_d   = ST_DONE;
`endif
            end else begin
              state_d = ST_DATA;
            end
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_DONE: begin
          miso_d  = 1'b0;
          state_d = ST_DONE;
        end
        default: begin
          state_d   = ST_IDLE;
          bit_cnt_d = 3'd0;
          miso_d    = 1'b0;
        end
      endcase
    end
  end

  // Synchronisers, edge history and responder state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= {SYNC_STAGES{1'b0}};
      cs_sync_q   <= {SYNC_STAGES{1'b1}};
      mosi_sync_q <= {SYNC_STAGES{1'b0}};
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 7'd0;
      addr_q      <= 7'd0;
      rw_q        <= 1'b0;
      tx_q        <= {BYTE_W{1'b0}};
      miso_q      <= 1'b0;
      load_q      <= 1'b0;
      wr_pend_q   <= 1'b0;
      wr_addr_q   <= 7'd0;
      wr_data_q   <= {BYTE_W{1'b0}};
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      addr_q      <= addr_d;
      rw_q        <= rw_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      load_q      <= load_d;
      wr_pend_q   <= wr_pend_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  tt_spi_regfile #(
    .NREGS  (NREGS),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (wr_pend_q),
    .waddr     (wr_addr_q),
    .wdata     (wr_data_q),
    .raddr     (addr_q),
    .rdata     (rdata_s),
    .regs_flat (regs_flat)
  );

endmodule

// File: tb/tb_tt_spi_responder.sv
// Directed bench for tt_spi_responder: writes, reads, abort, range, burst, reset, fast sclk.
module tb_tt_spi_responder;

  logic        clk = 1'b0;
  logic        rst_n, ena, sclk, cs_n, mosi;
  logic        miso, miso_oe, busy;
  logic [63:0] regs_flat;
  logic [7:0]  rx, rx2;
  int          total = 0;
  int          bad = 0;

`ifdef SPI_AUTOINC_EN
  localparam logic [63:0] EXP_BURST = 64'h22110000_A55A0033;
  localparam logic [7:0]  EXP_RD2   = 8'h22;
`else
  localparam logic [63:0] EXP_BURST = 64'h00110000_A55A0000;
  localparam logic [7:0]  EXP_RD2   = 8'h00;
`endif

  always #10 clk = ~clk;

  tt_spi_responder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .busy      (busy),
    .regs_flat (regs_flat)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic xbits(input logic [7:0] tx, input int n, input int half, output logic [7:0] r);
    r = 8'h00;
    for (int i = 0; i < n; i++) begin
      mosi = tx[7-i];
      #(half);
      r[7-i] = miso;
      sclk = 1'b1;
      #(half);
      sclk = 1'b0;
    end
  endtask

  task automatic cs_lo();
    cs_n = 1'b0;
    #200;
  endtask

  task automatic cs_hi();
    #200;
    cs_n = 1'b1;
    #200;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d, input int half);
    logic [7:0] dummy;
    cs_lo();
    xbits(a, 8, half, dummy);
    xbits(d, 8, half, dummy);
    cs_hi();
  endtask

  task automatic rd(input logic [7:0] c, output logic [7:0] d);
    logic [7:0] dummy;
    cs_lo();
    xbits(c, 8, 100, dummy);
    xbits(8'h00, 8, 100, d);
    cs_hi();
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    #100;
    chk("rst_miso", 64'(miso), 64'd0);
    chk("rst_oe", 64'(miso_oe), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_regs", regs_flat, 64'd0);
    rst_n = 1'b1;
    #100;

    cs_lo();
    chk("frame_busy", 64'(busy), 64'd1);
    chk("frame_oe", 64'(miso_oe), 64'd1);
    xbits(8'h03, 8, 100, rx);
    xbits(8'hA5, 8, 100, rx);
    cs_hi();
    chk("wr03_regs", regs_flat, 64'h00000000_A5000000);
    chk("wr03_busy", 64'(busy), 64'd0);
    chk("wr03_oe", 64'(miso_oe), 64'd0);

    rd(8'h83, rx);
    chk("rd83", 64'(rx), 64'hA5);

    cs_lo();
    xbits(8'h02, 8, 100, rx);
    xbits(8'hFF, 5, 100, rx);
    cs_hi();
    chk("abort_regs", regs_flat, 64'h00000000_A5000000);
    chk("abort_busy", 64'(busy), 64'd0);
    wr(8'h02, 8'h5A, 100);
    chk("after_abort", regs_flat, 64'h00000000_A55A0000);

    wr(8'h0A, 8'hFF, 100);
    chk("oor_wr", regs_flat, 64'h00000000_A55A0000);
    rd(8'h8A, rx);
    chk("oor_rd", 64'(rx), 64'h00);

    cs_lo();
    xbits(8'h06, 8, 100, rx);
    xbits(8'h11, 8, 100, rx);
    xbits(8'h22, 8, 100, rx);
    xbits(8'h33, 8, 100, rx);
    cs_hi();
    chk("burst_regs", regs_flat, EXP_BURST);
    cs_lo();
    xbits(8'h86, 8, 100, rx);
    xbits(8'h00, 8, 100, rx);
    xbits(8'h00, 8, 100, rx2);
    cs_hi();
    chk("burst_rd1", 64'(rx), 64'h11);
    chk("burst_rd2", 64'(rx2), 64'(EXP_RD2));

    ena = 1'b0;
    #100;
    cs_lo();
    chk("ena0_oe", 64'(miso_oe), 64'd0);
    chk("ena0_busy", 64'(busy), 64'd0);
    xbits(8'h00, 8, 100, rx);
    xbits(8'hFF, 8, 100, rx);
    cs_hi();
    chk("ena0_regs", regs_flat, EXP_BURST);
    ena = 1'b1;
    #100;

    cs_lo();
    xbits(8'h01, 8, 100, rx);
    xbits(8'hC3, 3, 100, rx);
    rst_n = 1'b0;
    #40;
    chk("midrst_regs", regs_flat, 64'd0);
    chk("midrst_oe", 64'(miso_oe), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_miso", 64'(miso), 64'd0);
    cs_n = 1'b1;
    sclk = 1'b0;
    #100;
    rst_n = 1'b1;
    #100;
    wr(8'h01, 8'hC3, 100);
    chk("post_rst_wr", regs_flat, 64'h00000000_0000C300);

    wr(8'h05, 8'h96, 40);
    wr(8'h04, 8'h69, 40);
    chk("fast_wr", regs_flat, 64'h00009669_0000C300);
    rd(8'h85, rx);
    chk("fast_rdback", 64'(rx), 64'h96);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
